// File: rtl/code_loader.sv
// code_loader: code RAM and byte-stream boot loader in front of the synapse316 core.
//
// A framed image arrives on an 8-bit valid/ready stream. It has the form
// SYNC, LEN_LO, LEN_HI, then LEN words (lo byte first), and optionally CSUM_LO, CSUM_HI.
// The words are written to code RAM at addresses 0..LEN-1.
// The core is held in reset until a frame completes.
// Fetches are served combinationally from the same RAM.
//
// Build option: define CODE_LOADER_CSUM_EN to require a trailing 16-bit additive checksum.
//
// Ports:
//   sysclk, sysreset       clock; asynchronous active-high reset
//   code_addr / code_out   core fetch address / fetched word (same-cycle)
//   rx_data/valid/ready    image byte stream; transfer on rx_valid && rx_ready
//   cpu_reset              core reset, high unless an image is running
//   load_done / load_error level status: image running / frame rejected
module code_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned IPR_WIDTH  = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic [IPR_WIDTH-1:0] code_addr,
  output logic [15:0]          code_out,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 cpu_reset,
  output logic                 load_done,
  output logic                 load_error
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [16:0] DepthLen = 17'(DEPTH);

`ifdef CODE_LOADER_CSUM_EN
  typedef enum logic [3:0] {
    StIdle, StLenLo, StLenHi, StDataLo, StDataHi, StCsumLo, StCsumHi, StRun, StError
  } state_e;
  // Frame body complete: the checksum trailer follows.
  localparam state_e StBodyDone = StCsumLo;
`else
  typedef enum logic [3:0] {
    StIdle, StLenLo, StLenHi, StDataLo, StDataHi, StRun, StError
  } state_e;
  localparam state_e StBodyDone = StRun;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;
  logic        rx_ready_q;
`ifdef CODE_LOADER_CSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic [15:0] mem_q [DEPTH];
  logic        mem_we;
  logic        accept;
  logic [15:0] rx_word;
  logic [15:0] len_rx;

  assign accept  = rx_valid && rx_ready_q;
  assign rx_word = {rx_data, lo_q};
  assign len_rx  = {rx_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    mem_we  = 1'b0;
`ifdef CODE_LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    if (accept) begin
      case (state_q)
        StIdle, StRun, StError: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = StLenLo;
            cnt_d   = '0;
`ifdef CODE_LOADER_CSUM_EN
            csum_d  = '0;
`endif
          end
        end
        StLenLo: begin
          len_d   = {len_q[15:8], rx_data};
          state_d = StLenHi;
        end
        StLenHi: begin
          len_d = len_rx;
          if ({1'b0, len_rx} > DepthLen) begin
            state_d = StError;
          end else if (len_rx == 16'd0) begin
            state_d = StBodyDone;
          end else begin
            state_d = StDataLo;
          end
        end
        StDataLo: begin
          lo_d    = rx_data;
          state_d = StDataHi;
        end
        StDataHi: begin
          mem_we  = 1'b1;
          cnt_d   = cnt_q + 16'd1;
`ifdef CODE_LOADER_CSUM_EN
          csum_d  = csum_q + rx_word;
`endif
          state_d = (cnt_q + 16'd1 == len_q) ? StBodyDone : StDataLo;
        end
`ifdef CODE_LOADER_CSUM_EN
        StCsumLo: begin
          lo_d    = rx_data;
          state_d = StCsumHi;
        end
        StCsumHi: begin
          state_d = (rx_word == csum_q) ? StRun : StError;
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      lo_q       <= '0;
      rx_ready_q <= 1'b0;
`ifdef CODE_LOADER_CSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      rx_ready_q <= 1'b1;
`ifdef CODE_LOADER_CSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Code RAM keeps its contents across sysreset.
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem_q[cnt_q[ADDR_WIDTH-1:0]] <= rx_word;
    end
  end

  // Out-of-range fetches read as zero rather than aliasing into the RAM.
  always_comb begin
    code_out = 16'h0000;
    if (code_addr[IPR_WIDTH-1:ADDR_WIDTH] == '0) begin
      code_out = mem_q[code_addr[ADDR_WIDTH-1:0]];
    end
  end

  assign rx_ready   = rx_ready_q;
  assign cpu_reset  = (state_q != StRun);
  assign load_done  = (state_q == StRun);
  assign load_error = (state_q == StError);

endmodule

// File: tb/tb_code_loader.sv
// tb_code_loader: scoreboard bench for code_loader.
// Stimulus pushes expected status transitions and fetch/snapshot checks into queues.
// A monitor pops and compares them on the falling clock edge.
// Status entries are compared whenever {cpu_reset, load_done, load_error} changes.
// Fetch and snapshot entries are compared one per cycle.
module tb_code_loader;

  logic        sysclk;
  logic        sysreset;
  logic [15:0] code_addr;
  logic [15:0] code_out;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  code_loader dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .code_addr (code_addr),
    .code_out  (code_out),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // is_fetch: compare code_out; else compare {rx_ready, cpu_reset, load_done, load_error}.
  typedef struct {
    string       name;
    logic        is_fetch;
    logic [15:0] exp;
  } chk_t;

  typedef struct {
    string      name;
    logic [2:0] exp;  // {cpu_reset, load_done, load_error}
  } st_t;

  chk_t chk_q[$];
  st_t  st_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor
  initial begin
    logic [2:0] prev_st;
    logic [2:0] cur_st;
    chk_t       c;
    st_t        s;
    prev_st = 3'b100;
    forever begin
      @(negedge sysclk);
      cur_st = {cpu_reset, load_done, load_error};
      if (cur_st !== prev_st) begin
        n_cmp++;
        if (st_q.size() == 0) begin
          n_err++;
          $display("FAIL status_unexpected got %b want %b (no change expected)", cur_st, prev_st);
        end else begin
          s = st_q.pop_front();
          if (cur_st !== s.exp) begin
            n_err++;
            $display("FAIL %s status got %b want %b", s.name, cur_st, s.exp);
          end
        end
        prev_st = cur_st;
      end
      if (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        n_cmp++;
        if (c.is_fetch) begin
          if (code_out !== c.exp) begin
            n_err++;
            $display("FAIL %s code_out got %h want %h", c.name, code_out, c.exp);
          end
        end else begin
          if ({rx_ready, cur_st} !== c.exp[3:0]) begin
            n_err++;
            $display("FAIL %s flags got %b want %b", c.name, {rx_ready, cur_st}, c.exp[3:0]);
          end
        end
      end
    end
  end

  task automatic expect_st(input string name, input logic [2:0] exp);
    st_q.push_back('{name: name, exp: exp});
  endtask

  task automatic snapshot(input string name, input logic [3:0] exp);
    chk_q.push_back('{name: name, is_fetch: 1'b0, exp: {12'h000, exp}});
    @(posedge sysclk);
    #1;
  endtask

  task automatic fetch(input string name, input logic [15:0] a, input logic [15:0] exp);
    code_addr = a;
    chk_q.push_back('{name: name, is_fetch: 1'b1, exp: exp});
    @(posedge sysclk);
    #1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_ready_timeout got %b want 1", rx_ready);
    end
    @(posedge sysclk);
    #1;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic send_csum(input logic [7:0] lo, input logic [7:0] hi, input int gap);
`ifdef CODE_LOADER_CSUM_EN
    send(lo, gap);
    send(hi, gap);
`else
    if (gap < 0) $display("unused %h %h", lo, hi);
`endif
  endtask

  initial begin
    logic [15:0] w0;
    sysreset  = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    code_addr = 16'h0000;
    #1;
    snapshot("reset_state", 4'b0100);
    repeat (2) @(posedge sysclk);
    #1;
    sysreset = 1'b0;
    @(posedge sysclk);
    #1;
    snapshot("ready_after_release", 4'b1100);

    // Two-word image
    expect_st("t1_run", 3'b010);
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
    send(8'h34, 0); send(8'h12, 0); send(8'h78, 0); send(8'h56, 0);
    send_csum(8'hAC, 8'h68, 0);
    @(posedge sysclk); #1;
    fetch("t1_addr0", 16'h0000, 16'h1234);
    fetch("t1_addr1", 16'h0001, 16'h5678);
    fetch("t1_addr400", 16'h0400, 16'h0000);
    fetch("t1_addr401", 16'h0401, 16'h0000);
    w0 = 16'h1234;

`ifdef CODE_LOADER_CSUM_EN
    // Bad checksum, then resync; the A5 leaves the loader waiting for LEN_LO
    expect_st("t2_reload", 3'b100);
    expect_st("t2_error", 3'b101);
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0);
    send(8'hCD, 0); send(8'hAB, 0); send(8'h00, 0); send(8'h00, 0);
    @(posedge sysclk); #1;
    expect_st("t2_resync", 3'b100);
    expect_st("t2_run", 3'b010);
    send(8'hA5, 0);
    send(8'h01, 0); send(8'h00, 0); send(8'hEF, 0); send(8'hBE, 0);
    send(8'hEF, 0); send(8'hBE, 0);
    @(posedge sysclk); #1;
    fetch("t2_addr0", 16'h0000, 16'hBEEF);
    w0 = 16'hBEEF;
`endif

    // LEN = 1025 is rejected before any write
    expect_st("t3_reload", 3'b100);
    expect_st("t3_error", 3'b101);
    send(8'hA5, 0); send(8'h01, 0); send(8'h04, 0);
    send(8'h99, 0); send(8'h88, 0);
    @(posedge sysclk); #1;
    fetch("t3_addr0", 16'h0000, w0);
    fetch("t3_addr1", 16'h0001, 16'h5678);

    // LEN = 0 from ERROR: straight to RUN, RAM untouched
    expect_st("t4_resync", 3'b100);
    expect_st("t4_run", 3'b010);
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    send_csum(8'h00, 8'h00, 0);
    @(posedge sysclk); #1;
    fetch("t4_addr0", 16'h0000, w0);

    // Reload from RUN with 3-cycle gaps between bytes
    expect_st("t5_reload", 3'b100);
    expect_st("t5_run", 3'b010);
    send(8'hA5, 3); send(8'h01, 3); send(8'h00, 3); send(8'h11, 3); send(8'h22, 3);
    send_csum(8'h11, 8'h22, 3);
    fetch("t5_addr0", 16'h0000, 16'h2211);
    fetch("t5_addr1", 16'h0001, 16'h5678);

    // sysreset mid-frame abandons the frame; stray bytes ignored until sync
    expect_st("t6_reload", 3'b100);
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h34, 0);
    sysreset = 1'b1;
    snapshot("t6_in_reset", 4'b0100);
    @(posedge sysclk); #1;
    sysreset = 1'b0;
    @(posedge sysclk); #1;
    snapshot("t6_after_release", 4'b1100);
    fetch("t6_addr0", 16'h0000, 16'h2211);
    fetch("t6_addr1", 16'h0001, 16'h5678);
    send(8'h00, 0); send(8'hFF, 0);
    snapshot("t6_strays_ignored", 4'b1100);
    expect_st("t6_run", 3'b010);
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'h00, 0);
    send_csum(8'h01, 8'h00, 0);
    @(posedge sysclk); #1;
    fetch("t6_addr0_new", 16'h0000, 16'h0001);

    repeat (3) @(posedge sysclk);
    #1;
    while (st_q.size() > 0) begin
      st_t s;
      s = st_q.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL %s status got none want %b", s.name, s.exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
